// File: rtl/rx_iq_decim_gain.sv
// Receive IQ path: per-lane decimation (keep-last or floor average), saturating
// left-shift gain, and a first-word-fall-through output FIFO with overflow counting.
module rx_iq_decim_gain #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2,
  parameter int FIFO_AW       = 5
) (
  input  logic                                acc_clk,
  input  logic                                acc_rstn,
  input  logic [2*IQ_DATA_WIDTH*NUM_CH-1:0]   adc_data,
  input  logic                                adc_valid,
  input  logic [1:0]                          decim_log2,
  input  logic                                avg_en,
  input  logic [2:0]                          bb_gain,
  input  logic                                cfg_clear,
  output logic [2*IQ_DATA_WIDTH*NUM_CH-1:0]   data_to_acc,
  output logic                                emptyn_to_acc,
  input  logic                                acc_ask_data,
  output logic [FIFO_AW:0]                    fifo_count,
  output logic [15:0]                         overflow_cnt
);

  localparam int W      = IQ_DATA_WIDTH;
  localparam int NL     = 2 * NUM_CH;
  localparam int DW     = W * NL;
  localparam int ACC_W  = W + 3;
  localparam int GAIN_W = W + 7;
  localparam int DEPTH  = 1 << FIFO_AW;

  typedef logic signed [W-1:0]      lane_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [GAIN_W-1:0] gain_t;

  localparam gain_t SAT_MAX = {{8{1'b0}}, {(W-1){1'b1}}};
  localparam gain_t SAT_MIN = {{8{1'b1}}, {(W-1){1'b0}}};
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  // Decimator state
  logic [2:0] phase_q, phase_d;
  logic [2:0] last_phase;
  logic       grp_done;
  acc_t       acc_q     [NL];
  acc_t       acc_d     [NL];
  acc_t       acc_sum   [NL];
  acc_t       acc_shift [NL];

  // Pipeline stages
  lane_t            s1_data_q [NL];
  lane_t            s1_data_d [NL];
  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s2_data_q, s2_data_d;
  logic             s2_valid_q, s2_valid_d;
  gain_t            gain_val  [NL];

  // FIFO
  logic [DW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [15:0]        ovf_q, ovf_d;
  logic               full, pop, wr_en;

  // Wraps to 7 for decim_log2=3 because the subtraction is done in 3 bits.
  assign last_phase = (3'b001 << decim_log2) - 3'b001;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    phase_d    = phase_q;
    grp_done   = adc_valid && (phase_q == last_phase);
    s1_valid_d = grp_done;
    for (int l = 0; l < NL; l++) begin
      acc_sum[l]   = (phase_q == 3'd0) ? acc_t'(lane_t'(adc_data[l*W +: W]))
                                       : acc_q[l] + acc_t'(lane_t'(adc_data[l*W +: W]));
      acc_shift[l] = acc_sum[l] >>> decim_log2;
      acc_d[l]     = adc_valid ? acc_sum[l] : acc_q[l];
      s1_data_d[l] = grp_done ? (avg_en ? lane_t'(acc_shift[l]) : lane_t'(adc_data[l*W +: W]))
                              : s1_data_q[l];
    end
    if (adc_valid) begin
      phase_d = grp_done ? 3'd0 : phase_q + 3'd1;
    end
    if (cfg_clear) begin
      phase_d    = 3'd0;
      s1_valid_d = 1'b0;
      for (int l = 0; l < NL; l++) acc_d[l] = '0;
    end
  end

  always_comb begin
    s2_data_d  = s2_data_q;
    s2_valid_d = s1_valid_q && !cfg_clear;
    for (int l = 0; l < NL; l++) begin
      gain_val[l] = gain_t'(s1_data_q[l]) <<< bb_gain;
      if (s1_valid_q) begin
        if (gain_val[l] > SAT_MAX)      s2_data_d[l*W +: W] = lane_t'(SAT_MAX);
        else if (gain_val[l] < SAT_MIN) s2_data_d[l*W +: W] = lane_t'(SAT_MIN);
        else                            s2_data_d[l*W +: W] = lane_t'(gain_val[l]);
      end
    end
  end

  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = acc_ask_data && (count_q != '0);
    wr_en    = s2_valid_q && (!full || pop) && !cfg_clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (cfg_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
        2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (s2_valid_q && !wr_en && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge acc_clk or negedge acc_rstn) begin
    if (!acc_rstn) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
      for (int l = 0; l < NL; l++) begin
        acc_q[l]     <= '0;
        s1_data_q[l] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      for (int l = 0; l < NL; l++) begin
        acc_q[l]     <= acc_d[l];
        s1_data_q[l] <= s1_data_d[l];
      end
    end
  end

  // NOTE: the storage array is not reset; pointers and count alone decide which words are live.
  always_ff @(posedge acc_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s2_data_q;
  end

  assign data_to_acc   = mem_q[rd_ptr_q];
  assign emptyn_to_acc = (count_q != '0);
  assign fifo_count    = count_q;
  assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_rx_iq_decim_gain.sv
// Self-checking bench for rx_iq_decim_gain: queue-based reference model plus
// directed scenarios (bypass, average, keep-last, saturation, overflow, reset/clear) and random traffic.
module tb_rx_iq_decim_gain;

  localparam int NL    = 4;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [1:0]  decim_log2 = '0;
  logic        avg_en = 1'b0;
  logic [2:0]  bb_gain = '0;
  logic        cfg_clear = 1'b0;
  logic [63:0] data_to_acc;
  logic        emptyn_to_acc;
  logic        acc_ask_data = 1'b0;
  logic [5:0]  fifo_count;
  logic [15:0] overflow_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rx_iq_decim_gain #(.IQ_DATA_WIDTH(16), .NUM_CH(2), .FIFO_AW(5)) dut (
    .acc_clk       (clk),
    .acc_rstn      (rstn),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .decim_log2    (decim_log2),
    .avg_en        (avg_en),
    .bb_gain       (bb_gain),
    .cfg_clear     (cfg_clear),
    .data_to_acc   (data_to_acc),
    .emptyn_to_acc (emptyn_to_acc),
    .acc_ask_data  (acc_ask_data),
    .fifo_count    (fifo_count),
    .overflow_cnt  (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  logic [63:0] grp[$];
  logic [63:0] pend1_d = '0, pend2_d = '0;
  bit          pend1_v = 0, pend2_v = 0;
  bit          pop_m;
  int          exp_ovf = 0;

  // Floor average (or last sample) per lane, then value*2^gain clamped to 16-bit signed.
  function automatic logic [63:0] group_result(input logic [63:0] smp[$], input bit avg, input int gain);
    logic [63:0] r = '0;
    for (int l = 0; l < NL; l++) begin
      int s, n, v;
      logic [15:0] raw;
      if (avg) begin
        s = 0;
        foreach (smp[k]) begin
          raw = smp[k][l*16 +: 16];
          s += int'($signed(raw));
        end
        n = smp.size();
        v = s / n;
        if ((s % n) != 0 && s < 0) v--;
      end else begin
        raw = smp[smp.size()-1][l*16 +: 16];
        v = int'($signed(raw));
      end
      v = v * (1 << gain);
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      r[l*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete(); grp.delete();
      pend1_v = 0; pend2_v = 0; exp_ovf = 0;
    end else if (cfg_clear) begin
      exp_q.delete(); grp.delete();
      pend1_v = 0; pend2_v = 0;
    end else begin
      pop_m = acc_ask_data && (exp_q.size() != 0);
      if (pend2_v) begin
        if (exp_q.size() < DEPTH || pop_m) begin
          if (pop_m) void'(exp_q.pop_front());
          pop_m = 0;
          exp_q.push_back(pend2_d);
        end else if (exp_ovf < 65535) begin
          exp_ovf++;
        end
      end
      if (pop_m) void'(exp_q.pop_front());
      pend2_v = pend1_v; pend2_d = pend1_d;
      pend1_v = 0;
      if (adc_valid) begin
        grp.push_back(adc_data);
        if (grp.size() == (1 << decim_log2)) begin
          pend1_d = group_result(grp, avg_en, int'(bb_gain));
          pend1_v = 1;
          grp.delete();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk); #2;
    check("emptyn", 64'(emptyn_to_acc), 64'(exp_q.size() != 0));
    check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    check("overflow_cnt", 64'(overflow_cnt), 64'(exp_ovf));
    if (exp_q.size() != 0) check("head_word", data_to_acc, exp_q[0]);
  end

  // ---------------- stimulus ----------------
  function automatic logic [63:0] mk(input logic [15:0] i0, input logic [15:0] q0);
    return {$urandom(), q0, i0};
  endfunction

  task automatic step(input bit v, input logic [63:0] d, input bit ask);
    @(negedge clk);
    cfg_clear = 1'b0; adc_valid = v; adc_data = d; acc_ask_data = ask;
  endtask

  task automatic clear_cfg(input logic [1:0] dl, input bit av, input logic [2:0] g);
    @(negedge clk);
    cfg_clear = 1'b1; decim_log2 = dl; avg_en = av; bb_gain = g;
    adc_valid = 1'b1; adc_data = {$urandom(), $urandom()}; acc_ask_data = 1'b0;
  endtask

  task automatic idle(input int n, input bit ask);
    repeat (n) step(1'b0, '0, ask);
  endtask

  int ovf0;
  int ask_pct;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_emptyn", 64'(emptyn_to_acc), 64'd0);
    check("reset_count", 64'(fifo_count), 64'd0);
    check("reset_ovf", 64'(overflow_cnt), 64'd0);

    // Bypass ramp; the first valid is presented on the first edge after reset release.
    @(negedge clk);
    rstn = 1'b1; adc_valid = 1'b1; adc_data = mk(16'd1, 16'h1234);
    for (int i = 2; i <= 8; i++) step(1'b1, mk(16'(i), 16'(i * 3)), 1'b0);
    idle(3, 1'b0);
    check("bypass_model_head", 64'(exp_q[0][15:0]), 64'd1);
    check("bypass_count", 64'(fifo_count), 64'd8);
    check("bypass_head_i", 64'(data_to_acc[15:0]), 64'd1);
    idle(10, 1'b1);

    // Average over 4 with floor rounding.
    clear_cfg(2'd2, 1'b1, 3'd0);
    step(1'b1, mk(16'd1, 16'd0), 1'b0);
    step(1'b1, mk(16'd2, 16'd0), 1'b0);
    step(1'b1, mk(16'd3, 16'd0), 1'b0);
    step(1'b1, mk(16'hFFF9, 16'd0), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, mk((i == 3) ? 16'd5 : 16'd4, 16'd0), 1'b0);
    idle(4, 1'b0);
    check("avg_model_0", 64'(exp_q[0][15:0]), 64'h0000_FFFF);
    check("avg_model_1", 64'(exp_q[1][15:0]), 64'd4);
    check("avg_dut_head", 64'(data_to_acc[15:0]), 64'h0000_FFFF);
    idle(4, 1'b1);

    // Keep-last by 2 with gaps between valids.
    clear_cfg(2'd1, 1'b0, 3'd0);
    step(1'b1, mk(16'd10, 16'd0), 1'b0); idle(1, 1'b0);
    step(1'b1, mk(16'd11, 16'd0), 1'b0); idle(2, 1'b0);
    step(1'b1, mk(16'd12, 16'd0), 1'b0); idle(1, 1'b0);
    step(1'b1, mk(16'd13, 16'd0), 1'b0);
    idle(4, 1'b0);
    check("keep_count", 64'(fifo_count), 64'd2);
    check("keep_model_0", 64'(exp_q[0][15:0]), 64'd11);
    check("keep_model_1", 64'(exp_q[1][15:0]), 64'd13);
    idle(3, 1'b1);

    // Saturating gain.
    clear_cfg(2'd0, 1'b0, 3'd7);
    step(1'b1, mk(16'h0100, 16'hFF00), 1'b0);
    idle(3, 1'b0);
    check("sat_model_i", 64'(exp_q[0][15:0]), 64'h7FFF);
    check("sat_model_q", 64'(exp_q[0][31:16]), 64'h8000);
    check("sat_dut_i", 64'(data_to_acc[15:0]), 64'h7FFF);
    check("sat_dut_q", 64'(data_to_acc[31:16]), 64'h8000);
    clear_cfg(2'd0, 1'b0, 3'd3);
    step(1'b1, mk(16'h0010, 16'h0000), 1'b0);
    idle(3, 1'b0);
    check("gain3_model_i", 64'(exp_q[0][15:0]), 64'h0080);
    check("gain3_dut_i", 64'(data_to_acc[15:0]), 64'h0080);
    idle(2, 1'b1);

    // Random traffic; low pop rates in some rounds drive the FIFO into overflow.
    for (int r = 0; r < 8; r++) begin
      clear_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      ask_pct = (r % 2 == 0) ? 85 : 15;
      repeat (250) step(1'($urandom_range(0, 99) < 70), {$urandom(), $urandom()},
                        1'($urandom_range(0, 99) < ask_pct));
    end

    // Full FIFO: 35 words with no pops, then push+pop while full.
    clear_cfg(2'd0, 1'b0, 3'd0);
    ovf0 = exp_ovf;
    for (int i = 0; i < 35; i++) step(1'b1, mk(16'(i + 100), 16'(i)), 1'b0);
    idle(3, 1'b0);
    check("full_count", 64'(fifo_count), 64'd32);
    check("full_ovf", 64'(overflow_cnt), 64'(ovf0 + 3));
    check("full_head", 64'(data_to_acc[15:0]), 64'd100);
    step(1'b1, mk(16'd200, 16'd0), 1'b0);
    step(1'b1, mk(16'd201, 16'd0), 1'b0);
    step(1'b1, mk(16'd202, 16'd0), 1'b1);
    step(1'b1, mk(16'd203, 16'd0), 1'b1);
    idle(2, 1'b1);
    idle(1, 1'b0);
    check("pushpop_count", 64'(fifo_count), 64'd32);
    check("pushpop_ovf", 64'(overflow_cnt), 64'(ovf0 + 3));
    idle(34, 1'b1);

    // Asynchronous reset mid-group with five words stored.
    clear_cfg(2'd2, 1'b1, 3'd1);
    for (int i = 0; i < 20; i++) step(1'b1, {$urandom(), $urandom()}, 1'b0);
    idle(3, 1'b0);
    step(1'b1, {$urandom(), $urandom()}, 1'b0);
    step(1'b1, {$urandom(), $urandom()}, 1'b0);
    check("pre_reset_count", 64'(fifo_count), 64'd5);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("async_rst_emptyn", 64'(emptyn_to_acc), 64'd0);
    check("async_rst_count", 64'(fifo_count), 64'd0);
    check("async_rst_ovf", 64'(overflow_cnt), 64'd0);
    idle(2, 1'b0);
    @(negedge clk); rstn = 1'b1;

    // cfg_clear at phase 2: the next four valids form one fresh group.
    clear_cfg(2'd2, 1'b0, 3'd0);
    step(1'b1, mk(16'h0011, 16'd0), 1'b0);
    step(1'b1, mk(16'h0012, 16'd0), 1'b0);
    clear_cfg(2'd2, 1'b0, 3'd0);
    for (int i = 1; i <= 4; i++) step(1'b1, mk(16'(16'h0020 + i), 16'd0), 1'b0);
    idle(3, 1'b0);
    check("clr_count", 64'(fifo_count), 64'd1);
    check("clr_model", 64'(exp_q[0][15:0]), 64'h0024);
    check("clr_dut", 64'(data_to_acc[15:0]), 64'h0024);
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_iq_decim_gain.md
RX_IQ_DECIM_GAIN -- requirements
Module: rx_iq_decim_gain

Interface
REQ-001 SHALL have parameter IQ_DATA_WIDTH, default 16, signed bits per I or Q sample.
REQ-002 SHALL have parameter NUM_CH, default 2, number of IQ channels carried side by side.
REQ-003 SHALL have parameter FIFO_AW, default 5, output FIFO depth 2^FIFO_AW words.
REQ-004 SHALL have port acc_clk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port acc_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port adc_data  input  2*IQ_DATA_WIDTH*NUM_CH  per channel c: I at [c*2W +: W], Q at [c*2W+W +: W] (W=IQ_DATA_WIDTH).
REQ-007 SHALL have port adc_valid  input  1  adc_data valid this cycle.
REQ-008 SHALL have port decim_log2  input  2  decimation ratio 2^decim_log2 (1,2,4,8).
REQ-009 SHALL have port avg_en  input  1  1 = average the group, 0 = keep last sample of the group.
REQ-010 SHALL have port bb_gain  input  3  left-shift gain 0..7 with saturation.
REQ-011 SHALL have port cfg_clear  input  1  synchronous flush of decimator phase, accumulators and FIFO.
REQ-012 SHALL have port data_to_acc  output  2*IQ_DATA_WIDTH*NUM_CH  FIFO head word, same lane layout as adc_data.
REQ-013 SHALL have port emptyn_to_acc  output  1  FIFO not empty.
REQ-014 SHALL have port acc_ask_data  input  1  pop request.
REQ-015 SHALL have port fifo_count  output  FIFO_AW+1  current FIFO occupancy.
REQ-016 SHALL have port overflow_cnt  output  16  dropped output words, saturating at 16'hFFFF.

Function
REQ-017 SHALL keep a phase counter 0..2^decim_log2-1 that advances on each adc_valid and wraps to 0 after the last phase.
REQ-018 SHALL, with avg_en=0, emit the sample taken on the last phase of each group; with decim_log2=0, emit every valid sample.
REQ-019 SHALL, with avg_en=1, sum each lane over the group in an IQ_DATA_WIDTH+3 bit signed accumulator, then arithmetic-shift right by decim_log2 (floor rounding).
REQ-020 SHALL restart the accumulator on phase 0, loading the phase-0 sample without adding stale sum.
REQ-021 SHALL apply gain per lane as value<<bb_gain, clamped to [-2^(W-1), 2^(W-1)-1].
REQ-022 SHALL register the decimator output (stage 1) and the gain/saturation output (stage 2), then write the FIFO: for an adc_valid completing a group in cycle 0, emptyn_to_acc SHALL be 1 in cycle 3 if the FIFO was empty.
REQ-023 SHALL present the FIFO head combinationally on data_to_acc (first-word fall-through); data_to_acc is don't-care while emptyn_to_acc=0.
REQ-024 SHALL pop on a cycle where acc_ask_data=1 and emptyn_to_acc=1; SHALL ignore acc_ask_data while empty.
REQ-025 SHALL accept a write when full if a pop occurs in the same cycle; fifo_count SHALL be unchanged on simultaneous push and pop.
REQ-026 SHALL drop the write, leave FIFO contents intact and increment overflow_cnt when full with no pop.
REQ-027 SHALL wrap read/write pointers modulo 2^FIFO_AW; fifo_count ranges 0..2^FIFO_AW.
REQ-028 SHALL sample decim_log2, avg_en and bb_gain each cycle; any change of decim_log2 or avg_en is not glitch-protected and SHALL be accompanied by cfg_clear.
REQ-029 SHALL, on cfg_clear=1, in the next cycle have phase=0, accumulators=0, pipeline valids=0, fifo_count=0, emptyn_to_acc=0; adc_valid in the cfg_clear cycle is discarded; overflow_cnt is not cleared.

Reset
REQ-030 SHALL, while acc_rstn=0, asynchronously force phase, accumulators, pipeline registers, FIFO pointers, fifo_count, overflow_cnt to 0 and emptyn_to_acc to 0.
REQ-031 SHALL discard any partially accumulated group and in-flight words when reset asserts mid-operation.
REQ-032 SHALL accept the first adc_valid on the first rising edge after acc_rstn deasserts.

Verification
REQ-033 Decim bypass: decim_log2=0, avg_en=0, bb_gain=0, ramp I=1,2,3.. -> emptyn in cycle 3 after first valid, pops return 1,2,3.. in order.
REQ-034 Average: decim_log2=2, avg_en=1, I samples 1,2,3,-7 -> output I=floor(-1/4)=-1; samples 4,4,4,5 -> 4.
REQ-035 Keep-last with gaps: decim_log2=1, avg_en=0, samples 10,11,12,13 with adc_valid low between them -> outputs 11,13 only.
REQ-036 Saturation: bb_gain=7, I=16'h0100 -> 16'h7FFF; Q=16'hFF00 -> 16'h8000; bb_gain=3, I=16'h0010 -> 16'h0080.
REQ-037 Full/overflow: FIFO_AW=5, no pops, 35 outputs -> fifo_count=32, overflow_cnt=3, first 32 words intact; push+pop while full -> count stays 32, overflow_cnt unchanged.
REQ-038 Reset/clear: acc_rstn low mid-group with FIFO holding 5 words -> all outputs 0 immediately; cfg_clear with decim_log2=2 at phase 2 -> next four valid samples form a complete new group.
